// File: rtl/bus_capture_latch.sv
// Bus capture latch: reader end of the drive-enable bus. Merges the masked sources, waits a
// settle window after a request, captures the bus and acks. Multi-driver, partial-mask and
// floating-bus faults are flagged (sticky) at the capture edge.
module bus_capture_latch #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NSRC   = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NSRC*WIDTH-1:0] src_drive,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic                  load_req,
    input  logic                  clr_err,
    output logic                  load_ack,
    output logic                  busy,
    output logic [WIDTH-1:0]      q,
    output logic                  q_valid,
    output logic                  err_multi,
    output logic                  err_float
);

    // The settle counter is 4 bits wide; wider settle windows cannot be represented.
    if (SETTLE > 15) begin : gen_settle_check
        $error("bus_capture_latch: SETTLE must be in 0..15");
    end
    if (NSRC < 1 || NSRC > 8) begin : gen_nsrc_check
        $error("bus_capture_latch: NSRC must be in 1..8");
    end

    localparam logic [3:0] SettleCnt = 4'(SETTLE);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StAck  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q_valid_q, q_valid_d;
    logic             load_ack_q, load_ack_d;
    logic             busy_q, busy_d;
    logic             err_multi_q, err_multi_d;
    logic             err_float_q, err_float_d;

    logic [WIDTH-1:0] bus;
    logic [3:0]       drv_cnt;
    logic             any_partial;
    logic             multi_fault;
    logic             float_fault;
    logic             capture;

    // Wired-OR merge of gated sources plus driver count and partial-mask detection.
    always_comb begin
        bus         = '0;
        drv_cnt     = '0;
        any_partial = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            bus = bus | (src_data[i*WIDTH +: WIDTH] & src_drive[i*WIDTH +: WIDTH]);
            if (src_drive[i*WIDTH +: WIDTH] != '0) begin
                drv_cnt = drv_cnt + 4'd1;
                if (src_drive[i*WIDTH +: WIDTH] != '1) begin
                    any_partial = 1'b1;
                end
            end
        end
    end

    assign multi_fault = (drv_cnt >= 4'd2) || any_partial;
    assign float_fault = (drv_cnt == 4'd0);

    // Next-state logic for the request FSM, capture register and sticky fault flags.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        q_d        = q_q;
        q_valid_d  = q_valid_q;
        load_ack_d = 1'b0;
        capture    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (load_req) begin
                    state_d   = StWait;
                    cnt_d     = SettleCnt;
                    q_valid_d = 1'b0;
                end
            end
            StWait: begin
                if (!load_req) begin
                    // Abandoned request: leave q and the flags alone, q_valid stays low.
                    state_d = StIdle;
                end else if (cnt_q == 4'd0) begin
                    capture    = 1'b1;
                    q_d        = float_fault ? '0 : bus;
                    q_valid_d  = 1'b1;
                    load_ack_d = 1'b1;
                    state_d    = StAck;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StWait) || (state_d == StAck);

        // A fault arriving on the same edge as clr_err must survive, so set follows clear.
        err_multi_d = err_multi_q;
        err_float_d = err_float_q;
        if (clr_err) begin
            err_multi_d = 1'b0;
            err_float_d = 1'b0;
        end
        if (capture && multi_fault) begin
            err_multi_d = 1'b1;
        end
        if (capture && float_fault) begin
            err_float_d = 1'b1;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            q_q         <= '0;
            q_valid_q   <= 1'b0;
            load_ack_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_multi_q <= 1'b0;
            err_float_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            q_q         <= q_d;
            q_valid_q   <= q_valid_d;
            load_ack_q  <= load_ack_d;
            busy_q      <= busy_d;
            err_multi_q <= err_multi_d;
            err_float_q <= err_float_d;
        end
    end

    assign load_ack  = load_ack_q;
    assign busy      = busy_q;
    assign q         = q_q;
    assign q_valid   = q_valid_q;
    assign err_multi = err_multi_q;
    assign err_float = err_float_q;

endmodule

// File: tb/tb_bus_capture_latch.sv
// Testbench for bus_capture_latch: two instances (SETTLE=1 and SETTLE=3) share the bus
// sources; expected captures are queued when a request is driven and popped on load_ack.
module tb_bus_capture_latch;

    localparam int unsigned W = 8;
    localparam int unsigned N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           clr_err;
    logic [W-1:0]   m [N];
    logic [W-1:0]   d [N];
    logic [N*W-1:0] src_drive;
    logic [N*W-1:0] src_data;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign src_drive[g*W +: W] = m[g];
        assign src_data[g*W +: W]  = d[g];
    end

    logic         req1, ack1, busy1, qv1, em1, ef1;
    logic [W-1:0] q1;
    logic         req3, ack3, busy3, qv3, em3, ef3;
    logic [W-1:0] q3;

    bus_capture_latch #(.WIDTH(W), .NSRC(N), .SETTLE(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_drive (src_drive),
        .src_data  (src_data),
        .load_req  (req1),
        .clr_err   (clr_err),
        .load_ack  (ack1),
        .busy      (busy1),
        .q         (q1),
        .q_valid   (qv1),
        .err_multi (em1),
        .err_float (ef1)
    );

    bus_capture_latch #(.WIDTH(W), .NSRC(N), .SETTLE(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_drive (src_drive),
        .src_data  (src_data),
        .load_req  (req3),
        .clr_err   (clr_err),
        .load_ack  (ack3),
        .busy      (busy3),
        .q         (q3),
        .q_valid   (qv3),
        .err_multi (em3),
        .err_float (ef3)
    );

    typedef struct packed {
        logic [W-1:0] q;
        logic         em;
        logic         ef;
    } exp_t;

    exp_t sb1[$];
    exp_t sb3[$];
    exp_t e1, e3;
    logic exp_em1, exp_ef1, exp_em3, exp_ef3;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference bus model from the bench's own mask/data tables.
    function automatic void model(output logic [W-1:0] b, output logic multi,
                                  output logic flt);
        int cnt = 0;
        b     = '0;
        multi = 1'b0;
        for (int i = 0; i < N; i++) begin
            b = b | (d[i] & m[i]);
            if (m[i] != 8'h00) cnt++;
            if (m[i] != 8'h00 && m[i] != 8'hFF) multi = 1'b1;
        end
        if (cnt >= 2) multi = 1'b1;
        flt = (cnt == 0);
    endfunction

    task automatic set_req(input int sel, input logic v);
        if (sel == 1) req1 = v;
        else          req3 = v;
    endtask

    function automatic logic ack_of(input int sel);
        return (sel == 1) ? ack1 : ack3;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 1) ? busy1 : busy3;
    endfunction

    // Build the expected capture (including sticky flag state) and queue it.
    task automatic push_exp(input int sel);
        exp_t        e;
        logic [W-1:0] b;
        logic        bm, bf;
        model(b, bm, bf);
        e.q = b;
        if (sel == 1) begin
            if (clr_err) begin exp_em1 = 1'b0; exp_ef1 = 1'b0; end
            exp_em1 = exp_em1 | bm;
            exp_ef1 = exp_ef1 | bf;
            e.em = exp_em1;
            e.ef = exp_ef1;
            sb1.push_back(e);
        end else begin
            if (clr_err) begin exp_em3 = 1'b0; exp_ef3 = 1'b0; end
            exp_em3 = exp_em3 | bm;
            exp_ef3 = exp_ef3 | bf;
            e.em = exp_em3;
            e.ef = exp_ef3;
            sb3.push_back(e);
        end
    endtask

    // Full request on one instance; entered just after a falling edge.
    task automatic request(input int sel, input int settle, input string tag);
        int edges = 0;
        bit got   = 1'b0;
        push_exp(sel);
        set_req(sel, 1'b1);
        while (!got && edges < 20) begin
            @(negedge clk);
            edges++;
            if (ack_of(sel)) got = 1'b1;
        end
        check({tag, "_ack_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(edges), 32'(settle + 2));
        check({tag, "_busy_at_ack"}, 32'(busy_of(sel)), 32'd1);
        set_req(sel, 1'b0);
        clr_err = 1'b0;
        @(negedge clk);
        check({tag, "_ack_pulse"}, 32'(ack_of(sel)), 32'd0);
        check({tag, "_busy_done"}, 32'(busy_of(sel)), 32'd0);
    endtask

    // Scoreboard: compare on every ack.
    always @(negedge clk) begin
        if (rst_n && ack1) begin
            if (sb1.size() == 0) begin
                check("dut1_unexpected_ack", 32'd1, 32'd0);
            end else begin
                e1 = sb1.pop_front();
                check("dut1_q", 32'(q1), 32'(e1.q));
                check("dut1_q_valid", 32'(qv1), 32'd1);
                check("dut1_err_multi", 32'(em1), 32'(e1.em));
                check("dut1_err_float", 32'(ef1), 32'(e1.ef));
            end
        end
        if (rst_n && ack3) begin
            if (sb3.size() == 0) begin
                check("dut3_unexpected_ack", 32'd1, 32'd0);
            end else begin
                e3 = sb3.pop_front();
                check("dut3_q", 32'(q3), 32'(e3.q));
                check("dut3_q_valid", 32'(qv3), 32'd1);
                check("dut3_err_multi", 32'(em3), 32'(e3.em));
                check("dut3_err_float", 32'(ef3), 32'(e3.ef));
            end
        end
    end

    int edges;
    int nack;
    int last;

    initial begin
        rst_n   = 1'b1;
        clr_err = 1'b0;
        req1    = 1'b0;
        req3    = 1'b0;
        exp_em1 = 1'b0; exp_ef1 = 1'b0; exp_em3 = 1'b0; exp_ef3 = 1'b0;
        for (int i = 0; i < N; i++) begin m[i] = 8'h00; d[i] = 8'h00; end
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_dut1", 32'({ack1, busy1, q1, qv1, em1, ef1}), 32'd0);
        check("reset_dut3", 32'({ack3, busy3, q3, qv3, em3, ef3}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single clean driver.
        m[1] = 8'hFF; d[1] = 8'hA5;
        request(1, 1, "t1");
        check("t1_q_const", 32'(q1), 32'h0000_00A5);

        // Two full drivers, then a clean capture with the flag still sticky.
        m[1] = 8'h00; d[1] = 8'h00;
        m[0] = 8'hFF; d[0] = 8'h0F;
        m[2] = 8'hFF; d[2] = 8'hF0;
        request(1, 1, "t2a");
        check("t2_q_const", 32'(q1), 32'h0000_00FF);
        m[2] = 8'h00;
        request(1, 1, "t2b");
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        exp_em1 = 1'b0; exp_ef1 = 1'b0; exp_em3 = 1'b0; exp_ef3 = 1'b0;
        check("t2_clr_multi", 32'(em1), 32'd0);
        check("t2_clr_float", 32'(ef1), 32'd0);

        // Floating bus with clr_err held through the capture edge: the set wins.
        for (int i = 0; i < N; i++) begin m[i] = 8'h00; d[i] = 8'hFF; end
        clr_err = 1'b1;
        request(1, 1, "t3");
        check("t3_q_const", 32'(q1), 32'd0);
        check("t3_float_held", 32'(ef1), 32'd1);

        // Abort on the SETTLE=3 instance after a good capture.
        for (int i = 0; i < N; i++) d[i] = 8'h00;
        m[1] = 8'hFF; d[1] = 8'h5A;
        request(3, 3, "t4pre");
        set_req(3, 1'b1);
        @(negedge clk);
        check("t4_busy_wait", 32'(busy3), 32'd1);
        check("t4_qv_cleared", 32'(qv3), 32'd0);
        set_req(3, 1'b0);
        d[1] = 8'hC3;
        @(negedge clk);
        check("t4_abort_idle", 32'(busy3), 32'd0);
        check("t4_abort_noack", 32'(ack3), 32'd0);
        check("t4_abort_q", 32'(q3), 32'h0000_005A);
        check("t4_abort_qv", 32'(qv3), 32'd0);
        repeat (6) @(negedge clk);
        check("t4_still_idle", 32'({ack3, busy3, qv3}), 32'd0);

        // Continuous request with a partial mask on src3.
        m[1] = 8'h00; d[1] = 8'h00;
        m[3] = 8'h0F; d[3] = 8'h3C;
        repeat (3) push_exp(1);
        set_req(1, 1'b1);
        edges = 0; nack = 0; last = 0;
        while (nack < 3 && edges < 40) begin
            @(negedge clk);
            edges++;
            if (ack1) begin
                nack++;
                if (nack == 1) check("t5_first_latency", 32'(edges), 32'd3);
                else           check("t5_ack_period", 32'(edges - last), 32'd4);
                last = edges;
            end
        end
        set_req(1, 1'b0);
        check("t5_ack_count", 32'(nack), 32'd3);
        check("t5_q_const", 32'(q1), 32'h0000_000C);
        @(negedge clk);

        // Asynchronous reset during WAIT, then a clean request.
        m[3] = 8'h00; d[3] = 8'h00;
        m[1] = 8'hFF; d[1] = 8'h77;
        set_req(3, 1'b1);
        repeat (2) @(negedge clk);
        check("t6_busy_before", 32'(busy3), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_dut3", 32'({ack3, busy3, q3, qv3, em3, ef3}), 32'd0);
        check("t6_async_dut1", 32'({ack1, busy1, q1, qv1, em1, ef1}), 32'd0);
        set_req(3, 1'b0);
        exp_em1 = 1'b0; exp_ef1 = 1'b0; exp_em3 = 1'b0; exp_ef3 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        request(3, 3, "t6");
        check("t6_q_const", 32'(q3), 32'h0000_0077);

        repeat (4) @(negedge clk);
        check("sb1_drained", 32'(sb1.size()), 32'd0);
        check("sb3_drained", 32'(sb3.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
